// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Brief   : Two-port round-robin arbiter and access sequencer for the ram
//           block. Serialises requests, holds the ram bus stable for a full
//           cycle before the edge-triggered select strobe, acks with data.
// Revision: 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int word_size   = 20,
    parameter int word_amount = 30,
    localparam int DW = word_size + 1,
    localparam int AW = $clog2(word_amount) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          op0,
    input  logic          op1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic [AW-1:0] ram_address,
    output logic          ram_operation,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_select,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW-1:0] c_max_addr = AW'(word_amount);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    // r_last_grant doubles as "port currently in flight" once a grant is made
    logic          r_last_grant;
    logic          r_err;
    logic          r_ack0, r_ack1, r_err0, r_err1;
    logic          r_busy;
    logic          r_ram_select;
    logic          r_ram_operation;
    logic [AW-1:0] r_ram_address;
    logic [DW-1:0] r_ram_wdata;
    logic [DW-1:0] r_rdata0, r_rdata1;

    logic          w_any_req;
    logic          w_grant;
    logic          w_op_sel;
    logic [AW-1:0] w_addr_sel;
    logic [DW-1:0] w_wdata_sel;
    logic          w_addr_bad;
    logic          w_grant_eff;
    logic          w_err_eff;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        w_any_req   = req0 | req1;
        w_grant     = (req0 && req1) ? ~r_last_grant : req1;
        w_op_sel    = w_grant ? op1    : op0;
        w_addr_sel  = w_grant ? addr1  : addr0;
        w_wdata_sel = w_grant ? wdata1 : wdata0;
        w_addr_bad  = (w_addr_sel > c_max_addr);
    end

    // Next-state decode; grant/error are taken live in IDLE, from registers afterwards
    always_comb begin
        w_state_next = r_state;
        w_grant_eff  = r_last_grant;
        w_err_eff    = r_err;
        case (r_state)
            S_IDLE: begin
                w_grant_eff = w_grant;
                w_err_eff   = w_addr_bad;
                if (w_any_req) begin
                    w_state_next = w_addr_bad ? S_DONE : S_SETUP;
                end
            end
            S_SETUP:  w_state_next = S_STROBE;
            S_STROBE: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant capture, ram bus loading and read-data capture on the edge leaving STROBE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant    <= 1'b1;
            r_err           <= 1'b0;
            r_ram_address   <= '0;
            r_ram_operation <= 1'b0;
            r_ram_wdata     <= '0;
            r_rdata0        <= '0;
            r_rdata1        <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_last_grant <= w_grant;
                r_err        <= w_addr_bad;
                if (!w_addr_bad) begin
                    r_ram_address   <= w_addr_sel;
                    r_ram_operation <= w_op_sel;
                    r_ram_wdata     <= w_wdata_sel;
                end
            end
            if (r_state == S_STROBE && !r_ram_operation) begin
                if (r_last_grant) begin
                    r_rdata1 <= ram_rdata;
                end else begin
                    r_rdata0 <= ram_rdata;
                end
            end
        end
    end

    // Registered, glitch-free outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_select <= 1'b0;
            r_busy       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_ram_select <= (w_state_next == S_STROBE);
            r_busy       <= (w_state_next != S_IDLE);
            r_ack0       <= (w_state_next == S_DONE) && !w_grant_eff;
            r_ack1       <= (w_state_next == S_DONE) &&  w_grant_eff;
            r_err0       <= (w_state_next == S_DONE) && !w_grant_eff && w_err_eff;
            r_err1       <= (w_state_next == S_DONE) &&  w_grant_eff && w_err_eff;
        end
    end

    assign ack0          = r_ack0;
    assign ack1          = r_ack1;
    assign err0          = r_err0;
    assign err1          = r_err1;
    assign rdata0        = r_rdata0;
    assign rdata1        = r_rdata1;
    assign busy          = r_busy;
    assign ram_address   = r_ram_address;
    assign ram_operation = r_ram_operation;
    assign ram_wdata     = r_ram_wdata;
    assign ram_select    = r_ram_select;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_arbiter
// Brief   : Self-checking bench for ram_arbiter with a behavioural ram model,
//           a reference memory and an ack-ordered scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int DW = 21;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err0, err1, busy;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_address;
    logic          ram_operation, ram_select;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    ram_arbiter #(.word_size(20), .word_amount(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .ram_address(ram_address), .ram_operation(ram_operation),
        .ram_wdata(ram_wdata), .ram_select(ram_select), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          err;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        bit          port;
        bit          op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit          xerr;
        int          xlat;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            sel_count = 0;
    exp_t          sb[$];
    logic [DW-1:0] mem[64];
    logic [DW-1:0] ref_mem[64];
    logic [DW-1:0] sh[2];
    logic          prev_sel = 1'b0;
    exp_t          mon_e;
    logic          mon_p;
    vec_t          tbl[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Behavioural ram: acts on the rising edge of select
    always @(posedge ram_select) begin
        sel_count++;
        if (ram_operation) mem[ram_address] = ram_wdata;
        else               ram_rdata = mem[ram_address];
    end

    // Scoreboard monitor on the falling edge
    always @(negedge clk) begin
        if (rst_n && (ack0 || ack1)) begin
            if (ack0 && ack1) begin
                check("dual_ack", 1, 0);
            end else if (sb.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                mon_p = ack1;
                check("sb_port", mon_p, mon_e.port);
                check("sb_err", mon_p ? err1 : err0, mon_e.err);
                check("sb_rdata", mon_p ? rdata1 : rdata0, mon_e.rdata);
            end
        end
        if (rst_n && ((err0 && !ack0) || (err1 && !ack1))) check("err_without_ack", 1, 0);
        if (rst_n && ram_select) check("sel_width", prev_sel, 0);
        prev_sel = ram_select;
    end

    // Single transaction on one port; checks latency and select pulse count
    task automatic do_txn(input vec_t v, input string nm);
        exp_t e;
        int   n;
        int   s0;
        bit   got;
        if (!v.xerr && v.op)  ref_mem[v.addr] = v.wdata;
        if (!v.xerr && !v.op) sh[v.port] = ref_mem[v.addr];
        e.port = v.port; e.err = v.xerr; e.rdata = sh[v.port];
        sb.push_back(e);
        s0 = sel_count;
        @(negedge clk);
        if (v.port) begin req1 = 1; op1 = v.op; addr1 = v.addr; wdata1 = v.wdata; end
        else        begin req0 = 1; op0 = v.op; addr0 = v.addr; wdata0 = v.wdata; end
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (v.port ? ack1 : ack0) got = 1;
        end
        req0 = 0; req1 = 0;
        check({nm, "_latency"}, n, v.xlat);
        check({nm, "_sel_pulses"}, sel_count - s0, v.xerr ? 0 : 1);
    endtask

    initial begin
        exp_t e;
        int   n, n0, n1, acks, last_ack;
        vec_t v;

        for (int i = 0; i < 64; i++) begin
            mem[i]     = DW'(i * 32'h1111);
            ref_mem[i] = DW'(i * 32'h1111);
        end
        sh[0] = '0; sh[1] = '0;

        tbl[0] = '{1'b0, 1'b1, 6'd5,  21'h0ABCDE, 1'b0, 3};
        tbl[1] = '{1'b0, 1'b0, 6'd5,  21'h000000, 1'b0, 3};
        tbl[2] = '{1'b1, 1'b1, 6'd6,  21'h012345, 1'b0, 3};
        tbl[3] = '{1'b1, 1'b0, 6'd6,  21'h000000, 1'b0, 3};
        tbl[4] = '{1'b1, 1'b0, 6'd31, 21'h000000, 1'b1, 1};
        tbl[5] = '{1'b0, 1'b1, 6'd30, 21'h1FFFFF, 1'b0, 3};
        tbl[6] = '{1'b0, 1'b0, 6'd30, 21'h000000, 1'b0, 3};
        tbl[7] = '{1'b0, 1'b0, 6'd63, 21'h000000, 1'b1, 1};
        tbl[8] = '{1'b1, 1'b0, 6'd30, 21'h000000, 1'b0, 3};
        tbl[9] = '{1'b1, 1'b0, 6'd5,  21'h000000, 1'b0, 3};

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            req0 = 1'($urandom); req1 = 1'($urandom); op0 = 1'($urandom); op1 = 1'($urandom);
            addr0 = AW'($urandom); addr1 = AW'($urandom);
            wdata0 = DW'($urandom); wdata1 = DW'($urandom);
        end
        check("rst_ack_err", {ack0, ack1, err0, err1}, 0);
        check("rst_busy_sel", {busy, ram_select}, 0);
        check("rst_ram_bus", {ram_address, ram_operation, ram_wdata}, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst_n = 1;

        // Simultaneous requests right after reset: port0 first, port1 four cycles later
        sh[0] = ref_mem[5]; e.port = 0; e.err = 0; e.rdata = sh[0]; sb.push_back(e);
        sh[1] = ref_mem[6]; e.port = 1; e.err = 0; e.rdata = sh[1]; sb.push_back(e);
        @(negedge clk);
        req0 = 1; op0 = 0; addr0 = 6'd5;
        req1 = 1; op1 = 0; addr1 = 6'd6;
        n = 0; n0 = -1; n1 = -1;
        while ((req0 || req1) && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (ack0) begin n0 = n; req0 = 0; end
            if (ack1) begin n1 = n; req1 = 0; end
        end
        req0 = 0; req1 = 0;
        check("tie_ack0_cycle", n0, 3);
        check("tie_ack1_cycle", n1, 7);

        // Table-driven single-port accesses
        for (int i = 0; i < 10; i++) begin
            v = tbl[i];
            do_txn(v, $sformatf("vec%0d", i));
        end

        // Both ports held for six accesses: strict alternation starting at port0
        for (int i = 0; i < 6; i++) begin
            e.port = 1'(i % 2); e.err = 0;
            sh[e.port] = ref_mem[e.port ? 2 : 1];
            e.rdata = sh[e.port];
            sb.push_back(e);
        end
        @(negedge clk);
        req0 = 1; op0 = 0; addr0 = 6'd1;
        req1 = 1; op1 = 0; addr1 = 6'd2;
        acks = 0; last_ack = 0; n = 0;
        while (acks < 6 && n < 60) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (ack0 || ack1) begin
                if (acks > 0) check("rr_spacing", cyc - last_ack, 4);
                last_ack = cyc;
                acks++;
                if (acks == 6) begin req0 = 0; req1 = 0; end
            end
        end
        req0 = 0; req1 = 0;
        check("rr_ack_count", acks, 6);

        // Reset asserted during STROBE drops select asynchronously; no ack follows
        @(negedge clk);
        req0 = 1; op0 = 0; addr0 = 6'd7;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("strobe_sel_high", ram_select, 1);
        rst_n = 0;
        #1;
        check("async_sel_drop", ram_select, 0);
        check("async_busy_drop", busy, 0);
        req0 = 0;
        repeat (2) @(negedge clk);
        check("abort_rdata0", rdata0, 0);
        rst_n = 1;
        sh[0] = '0; sh[1] = '0;
        repeat (4) @(negedge clk);
        check("abort_no_pending", sb.size(), 0);
        v = '{1'b0, 1'b0, 6'd5, 21'h000000, 1'b0, 3};
        do_txn(v, "post_reset");
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
